// File: rtl/river_crossing_if.sv
// Command/status bundle between the board controls and the crossing controller.
// Latency: none, wires only.
// Backpressure: cmd_valid is taken only while cmd_ready is high; other requests are single-cycle pulses.
interface river_crossing_if;
    logic       start;
    logic       step;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic       cmd_ready;
    logic       pos_f;
    logic       pos_c;
    logic       pos_g;
    logic       pos_w;
    logic [3:0] moves;
    logic       busy;
    logic       done;
    logic       fail;
    logic       err;
    logic       alarm;

    // Board side: drives requests and observes the bank state.
    modport master (
        output start, step, cmd_valid, cmd,
        input  cmd_ready, pos_f, pos_c, pos_g, pos_w, moves, busy, done, fail, err, alarm
    );

    // Controller side.
    modport slave (
        input  start, step, cmd_valid, cmd,
        output cmd_ready, pos_f, pos_c, pos_g, pos_w, moves, busy, done, fail, err, alarm
    );
endinterface

// File: rtl/river_crossing_ctrl.sv
// Farmer/wolf/goat/cabbage crossing controller: manual moves or a stepped 7-move auto-solve.
// Latency: an accepted cmd or step updates positions, moves and state one cycle later.
// Backpressure: cmd_ready is high only in IDLE; commands outside IDLE are dropped, illegal ones pulse err.
module river_crossing_ctrl (
    input  logic              clk,
    input  logic              rst,
    river_crossing_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AUTO = 2'd1,
        S_DONE = 2'd2,
        S_FAIL = 2'd3
    } state_t;

    state_t     state;
    logic       pos_f, pos_c, pos_g, pos_w;
    logic [3:0] moves;
    logic [2:0] idx;
    logic       err;

    // Solution order: G, alone, C, G, W, alone, G (encoded like manual commands).
    function automatic logic [1:0] sol_move(input logic [2:0] i);
        case (i)
            3'd0:    sol_move = 2'b10;
            3'd1:    sol_move = 2'b00;
            3'd2:    sol_move = 2'b01;
            3'd3:    sol_move = 2'b10;
            3'd4:    sol_move = 2'b11;
            3'd5:    sol_move = 2'b00;
            default: sol_move = 2'b10;
        endcase
    endfunction

    logic [1:0] mv;
    logic       mv_legal;
    logic       nf, nc, ng, nw;
    logic       n_alarm, n_all;
    logic [3:0] moves_inc;

    // Candidate move (auto ROM in AUTO, manual command otherwise) and its resulting banks.
    always_comb begin
        mv = (state == S_AUTO) ? sol_move(idx) : bus.cmd;
        case (mv)
            2'b01:   mv_legal = (pos_c == pos_f);
            2'b10:   mv_legal = (pos_g == pos_f);
            2'b11:   mv_legal = (pos_w == pos_f);
            default: mv_legal = 1'b1;
        endcase
        nf        = ~pos_f;
        nc        = (mv == 2'b01) ? ~pos_c : pos_c;
        ng        = (mv == 2'b10) ? ~pos_g : pos_g;
        nw        = (mv == 2'b11) ? ~pos_w : pos_w;
        n_alarm   = (ng != nf) & ((nc != nf) | (nw != nf));
        n_all     = nf & nc & ng & nw;
        moves_inc = (moves == 4'd15) ? 4'd15 : moves + 4'd1;
    end

    // Single FSM: state, banks, move counter, solution index and the err pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            pos_f <= 1'b0;
            pos_c <= 1'b0;
            pos_g <= 1'b0;
            pos_w <= 1'b0;
            moves <= 4'd0;
            idx   <= 3'd0;
            err   <= 1'b0;
        end else begin
            err <= 1'b0;
            if (bus.start) begin
                // start wins over any step or command in every state.
                state <= S_AUTO;
                pos_f <= 1'b0;
                pos_c <= 1'b0;
                pos_g <= 1'b0;
                pos_w <= 1'b0;
                moves <= 4'd0;
                idx   <= 3'd0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.cmd_valid) begin
                            if (mv_legal) begin
                                pos_f <= nf;
                                pos_c <= nc;
                                pos_g <= ng;
                                pos_w <= nw;
                                moves <= moves_inc;
                                if (n_alarm)    state <= S_FAIL;
                                else if (n_all) state <= S_DONE;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    S_AUTO: begin
                        if (bus.step) begin
                            pos_f <= nf;
                            pos_c <= nc;
                            pos_g <= ng;
                            pos_w <= nw;
                            moves <= moves_inc;
                            idx   <= idx + 3'd1;
                            if (n_alarm)    state <= S_FAIL;
                            else if (n_all) state <= S_DONE;
                        end
                    end
                    default: ; // DONE/FAIL hold until start or rst
                endcase
            end
        end
    end

    assign bus.pos_f     = pos_f;
    assign bus.pos_c     = pos_c;
    assign bus.pos_g     = pos_g;
    assign bus.pos_w     = pos_w;
    assign bus.moves     = moves;
    assign bus.err       = err;
    assign bus.cmd_ready = (state == S_IDLE);
    assign bus.busy      = (state == S_AUTO);
    assign bus.done      = (state == S_DONE);
    assign bus.fail      = (state == S_FAIL);
    assign bus.alarm     = (pos_g != pos_f) & ((pos_c != pos_f) | (pos_w != pos_f));
endmodule

// File: tb/tb_river_crossing_ctrl.sv
// Self-checking bench for river_crossing_ctrl: vector table plus hand sequences.
// Latency: each vector is driven before an edge and its expectation checked 1 time unit after.
// Backpressure: expectations queue up at drive time and are popped once the edge has happened.
module tb_river_crossing_ctrl;
    logic clk;
    logic rst;
    river_crossing_if bus ();

    river_crossing_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs: {f,c,g,w}, moves, {cmd_ready,busy,done,fail}, err, alarm.
    typedef struct packed {
        logic [3:0] pos;
        logic [3:0] moves;
        logic [3:0] flags;
        logic       err;
        logic       alarm;
    } exp_t;

    typedef struct {
        string      name;
        logic       rst;
        logic       start;
        logic       step;
        logic       cmd_valid;
        logic [1:0] cmd;
        exp_t       exp;
    } vec_t;

    localparam logic [3:0] IDL = 4'b1000;
    localparam logic [3:0] AUT = 4'b0100;
    localparam logic [3:0] DON = 4'b0010;
    localparam logic [3:0] FAI = 4'b0001;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    vec_t tbl[$];

    function automatic vec_t mk(string n, logic r, logic s, logic st, logic cv, logic [1:0] c,
                                logic [3:0] p, logic [3:0] m, logic [3:0] fl, logic e, logic a);
        vec_t v;
        v.name = n; v.rst = r; v.start = s; v.step = st; v.cmd_valid = cv; v.cmd = c;
        v.exp.pos = p; v.exp.moves = m; v.exp.flags = fl; v.exp.err = e; v.exp.alarm = a;
        return v;
    endfunction

    // Drive one cycle, queue its expectation, then check after the edge.
    task automatic apply(input vec_t v);
        exp_t e;
        exp_t act;
        rst           = v.rst;
        bus.start     = v.start;
        bus.step      = v.step;
        bus.cmd_valid = v.cmd_valid;
        bus.cmd       = v.cmd;
        sb_q.push_back(v.exp);
        @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.start     = 1'b0;
        bus.step      = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd       = 2'b00;
        e   = sb_q.pop_front();
        act = {bus.pos_f, bus.pos_c, bus.pos_g, bus.pos_w, bus.moves,
               bus.cmd_ready, bus.busy, bus.done, bus.fail, bus.err, bus.alarm};
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s: got pos=%b moves=%0d rbdf=%b err=%b alarm=%b, want pos=%b moves=%0d rbdf=%b err=%b alarm=%b",
                     v.name, act.pos, act.moves, act.flags, act.err, act.alarm,
                     e.pos, e.moves, e.flags, e.err, e.alarm);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.step = 1'b0; bus.cmd_valid = 1'b0; bus.cmd = 2'b00;

        //         name          rst st  stp cv  cmd    pos      mv     flags e  a
        tbl.push_back(mk("reset",      1, 0, 0, 0, 2'b00, 4'b0000, 4'd0, IDL, 0, 0));
        tbl.push_back(mk("auto_start", 0, 1, 0, 0, 2'b00, 4'b0000, 4'd0, AUT, 0, 0));
        tbl.push_back(mk("auto_s1",    0, 0, 1, 0, 2'b00, 4'b1010, 4'd1, AUT, 0, 0));
        tbl.push_back(mk("auto_s2",    0, 0, 1, 0, 2'b00, 4'b0010, 4'd2, AUT, 0, 0));
        tbl.push_back(mk("auto_s3",    0, 0, 1, 0, 2'b00, 4'b1110, 4'd3, AUT, 0, 0));
        tbl.push_back(mk("auto_s4",    0, 0, 1, 0, 2'b00, 4'b0100, 4'd4, AUT, 0, 0));
        tbl.push_back(mk("auto_s5",    0, 0, 1, 0, 2'b00, 4'b1101, 4'd5, AUT, 0, 0));
        tbl.push_back(mk("auto_s6",    0, 0, 1, 0, 2'b00, 4'b0101, 4'd6, AUT, 0, 0));
        tbl.push_back(mk("auto_s7",    0, 0, 1, 0, 2'b00, 4'b1111, 4'd7, DON, 0, 0));
        tbl.push_back(mk("done_cmd",   0, 0, 0, 1, 2'b10, 4'b1111, 4'd7, DON, 0, 0));
        tbl.push_back(mk("done_step",  0, 0, 1, 0, 2'b00, 4'b1111, 4'd7, DON, 0, 0));
        tbl.push_back(mk("done_start", 0, 1, 0, 0, 2'b00, 4'b0000, 4'd0, AUT, 0, 0));
        tbl.push_back(mk("reset2",     1, 0, 0, 0, 2'b00, 4'b0000, 4'd0, IDL, 0, 0));
        tbl.push_back(mk("loss_w",     0, 0, 0, 1, 2'b11, 4'b1001, 4'd1, FAI, 0, 1));
        tbl.push_back(mk("fail_cmd",   0, 0, 0, 1, 2'b00, 4'b1001, 4'd1, FAI, 0, 1));
        tbl.push_back(mk("reset3",     1, 0, 0, 0, 2'b00, 4'b0000, 4'd0, IDL, 0, 0));
        tbl.push_back(mk("man_g",      0, 0, 0, 1, 2'b10, 4'b1010, 4'd1, IDL, 0, 0));
        tbl.push_back(mk("illegal_w",  0, 0, 0, 1, 2'b11, 4'b1010, 4'd1, IDL, 1, 0));
        tbl.push_back(mk("err_drop",   0, 0, 0, 0, 2'b00, 4'b1010, 4'd1, IDL, 0, 0));
        tbl.push_back(mk("start_cmd",  0, 1, 0, 1, 2'b10, 4'b0000, 4'd0, AUT, 0, 0));
        tbl.push_back(mk("p_s1",       0, 0, 1, 0, 2'b00, 4'b1010, 4'd1, AUT, 0, 0));
        tbl.push_back(mk("p_s2",       0, 0, 1, 0, 2'b00, 4'b0010, 4'd2, AUT, 0, 0));
        tbl.push_back(mk("p_s3",       0, 0, 1, 0, 2'b00, 4'b1110, 4'd3, AUT, 0, 0));
        tbl.push_back(mk("mid_start",  0, 1, 0, 0, 2'b00, 4'b0000, 4'd0, AUT, 0, 0));
        tbl.push_back(mk("start_step", 0, 1, 1, 0, 2'b00, 4'b0000, 4'd0, AUT, 0, 0));
        tbl.push_back(mk("auto_cmd",   0, 0, 0, 1, 2'b11, 4'b0000, 4'd0, AUT, 0, 0));
        tbl.push_back(mk("restep",     0, 0, 1, 0, 2'b00, 4'b1010, 4'd1, AUT, 0, 0));
        tbl.push_back(mk("rst_auto",   1, 0, 1, 0, 2'b00, 4'b0000, 4'd0, IDL, 0, 0));
        tbl.push_back(mk("b2b_g",      0, 0, 0, 1, 2'b10, 4'b1010, 4'd1, IDL, 0, 0));
        tbl.push_back(mk("b2b_f",      0, 0, 0, 1, 2'b00, 4'b0010, 4'd2, IDL, 0, 0));
        tbl.push_back(mk("b2b_c",      0, 0, 0, 1, 2'b01, 4'b1110, 4'd3, IDL, 0, 0));

        foreach (tbl[i]) apply(tbl[i]);

        // After reset, step alone never moves anything.
        apply(mk("idle_rst", 1, 0, 0, 0, 2'b00, 4'b0000, 4'd0, IDL, 0, 0));
        for (int i = 0; i < 10; i++)
            apply(mk("idle_step", 0, 0, 1, 0, 2'b00, 4'b0000, 4'd0, IDL, 0, 0));

        // Saturation: take G across, then 16 farmer-alone trips; moves caps at 15.
        begin
            logic       f;
            logic [3:0] m;
            apply(mk("sat_rst", 1, 0, 0, 0, 2'b00, 4'b0000, 4'd0, IDL, 0, 0));
            apply(mk("sat_g",   0, 0, 0, 1, 2'b10, 4'b1010, 4'd1, IDL, 0, 0));
            f = 1'b1;
            m = 4'd1;
            for (int i = 0; i < 16; i++) begin
                f = ~f;
                if (m != 4'd15) m = m + 4'd1;
                apply(mk("sat_f", 0, 0, 0, 1, 2'b00, {f, 1'b0, 1'b1, 1'b0}, m, IDL, 0, 0));
            end
            checks++;
            if (bus.moves !== 4'd15) begin
                errors++;
                $display("FAIL sat_hold: moves=%0d want 15", bus.moves);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
